// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and parity helper.
// The receiver uses the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Data is zero-extended to 9 bits, so one helper covers every legal width.
  function automatic logic par_bit(input logic [8:0] data, input logic [1:0] mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

  function automatic logic par_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count. Writes when full and reads when empty
// are ignored; full/empty derive from the registered count.
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CW-1:0]     count_o
);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [AW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                count_q;
  logic                         do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with input FIFO: start, LSB-first data, optional parity,
// 1 or 2 stop bits, one bit per enb tick. Frame config is latched at pop.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enb,
  input  logic                 wr_enb,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 tx,
  output logic                 busy,
  output logic                 full,
  output logic                 overflow,
  output logic [CNT_W-1:0]     fifo_count
);

  localparam int IW = $clog2(DATA_BITS);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] sh_q, fifo_dout;
  logic [IW-1:0]        idx_q;
  logic                 tx_q, busy_q, ovf_q, par_en_q, par_q, two_q;
  logic                 empty, pop, push_ok, frame_end, busy_d;
  logic [CNT_W-1:0]     count_d;

  uart_sync_fifo #(.DATA_W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_enb),
    .pop_i   (pop),
    .data_i  (data_in),
    .data_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  assign pop       = (state_q == IDLE) & enb & ~empty;
  assign push_ok   = wr_enb & ~full;
  assign frame_end = enb & (((state_q == STOP1) & ~two_q) | (state_q == STOP2));

  always_comb begin
    count_d = fifo_count;
    if (push_ok & ~pop)      count_d = fifo_count + CNT_W'(1);
    else if (pop & ~push_ok) count_d = fifo_count - CNT_W'(1);
  end

  // busy mirrors next-state values so it tracks state/count without lag.
  assign busy_d = pop | ((state_q != IDLE) & ~frame_end) | (count_d != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tx_q     <= 1'b1;
      sh_q     <= '0;
      idx_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      two_q    <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      ovf_q  <= wr_enb & full;
      if (enb) begin
        case (state_q)
          IDLE: if (!empty) begin
            sh_q     <= fifo_dout;
            par_en_q <= par_en(parity_mode);
            par_q    <= par_bit(9'(fifo_dout), parity_mode);
            two_q    <= two_stop;
            tx_q     <= 1'b0;
            state_q  <= START;
          end
          START: begin
            tx_q    <= sh_q[0];
            sh_q    <= sh_q >> 1;
            idx_q   <= '0;
            state_q <= DATA;
          end
          DATA: begin
            if (idx_q == IW'(DATA_BITS - 1)) begin
              if (par_en_q) begin
                tx_q    <= par_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP1;
              end
            end else begin
              idx_q <= idx_q + IW'(1);
              tx_q  <= sh_q[0];
              sh_q  <= sh_q >> 1;
            end
          end
          PARITY: begin
            tx_q    <= 1'b1;
            state_q <= STOP1;
          end
          STOP1:   state_q <= two_q ? STOP2 : IDLE;
          STOP2:   state_q <= IDLE;
          default: begin
            tx_q    <= 1'b1;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param: an 8-bit instance for framing, parity,
// FIFO and reset cases, plus a 5-bit instance for width and push/pop overlap.
module tb_uart_tx_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enb, wr_enb, two_stop;
  logic [7:0] data_in;
  logic [1:0] parity_mode;
  logic       tx, busy, full, overflow;
  logic [2:0] fifo_count;

  logic       enb5, wr5, ts5;
  logic [4:0] din5;
  logic [1:0] pm5;
  logic       tx5, busy5, full5, ovf5;
  logic [2:0] cnt5;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_param #(.DATA_BITS(8), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .enb(enb), .wr_enb(wr_enb), .data_in(data_in),
    .parity_mode(parity_mode), .two_stop(two_stop), .tx(tx), .busy(busy),
    .full(full), .overflow(overflow), .fifo_count(fifo_count)
  );

  uart_tx_fifo_param #(.DATA_BITS(5), .FIFO_DEPTH(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .enb(enb5), .wr_enb(wr5), .data_in(din5),
    .parity_mode(pm5), .two_stop(ts5), .tx(tx5), .busy(busy5),
    .full(full5), .overflow(ovf5), .fifo_count(cnt5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One baud tick: 16 clocks per bit; outputs sampled on the falling edge after the tick.
  task automatic pulse(input bit s);
    repeat (15) @(negedge clk);
    if (s) enb5 = 1'b1; else enb = 1'b1;
    @(negedge clk);
    enb  = 1'b0;
    enb5 = 1'b0;
  endtask

  task automatic cap(input bit s, input int n, output logic [15:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      pulse(s);
      v[i] = s ? tx5 : tx;
    end
  endtask

  task automatic push(input bit s, input logic [7:0] d);
    @(negedge clk);
    if (s) begin wr5 = 1'b1; din5 = d[4:0]; end
    else   begin wr_enb = 1'b1; data_in = d; end
    @(negedge clk);
    wr_enb = 1'b0;
    wr5    = 1'b0;
  endtask

  localparam logic [15:0] EXP_F [4] = '{16'h222, 16'h244, 16'h266, 16'h288};

  initial begin
    logic [15:0] v, a, b;
    int   ovf_n;
    logic full3, full4;

    rst_n = 1'b0; enb = 0; wr_enb = 0; two_stop = 0; data_in = '0; parity_mode = 2'b00;
    enb5 = 0; wr5 = 0; ts5 = 0; din5 = '0; pm5 = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", fifo_count, 0);
    rst_n = 1'b1;

    // Reset in the middle of a frame
    push(0, 8'hA5);
    cap(0, 3, v);
    chk("midrst_pre", v, 16'h002);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", fifo_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cap(0, 12, v);
    chk("midrst_quiet", v, 16'hFFF);
    chk("midrst_busy2", busy, 0);

    // 8N1
    push(0, 8'h53);
    chk("8n1_busy_up", busy, 1);
    cap(0, 10, v);
    chk("8n1_frame", v, 16'h2A6);
    pulse(0);
    chk("8n1_busy_dn", busy, 0);
    chk("8n1_idle_tx", tx, 1);

    // Parity even/odd, then two stop bits
    parity_mode = 2'b01;
    push(0, 8'h07);
    cap(0, 11, v);
    chk("even_frame", v, 16'h60E);
    pulse(0);
    parity_mode = 2'b10;
    push(0, 8'h07);
    cap(0, 11, v);
    chk("odd_frame", v, 16'h40E);
    pulse(0);
    parity_mode = 2'b01;
    two_stop = 1'b1;
    push(0, 8'h07);
    cap(0, 12, v);
    chk("2stop_frame", v, 16'hE0E);
    chk("2stop_busy", busy, 1);
    pulse(0);
    chk("2stop_busy_dn", busy, 0);
    two_stop = 1'b0;
    parity_mode = 2'b00;

    // FIFO fill and overflow with enb idle
    ovf_n = 0; full3 = 1'bx; full4 = 1'bx;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (overflow) ovf_n++;
      if (i == 3) full3 = full;
      if (i == 4) full4 = full;
      if (i < 5) begin wr_enb = 1'b1; data_in = 8'(8'h11 * (i + 1)); end
      else wr_enb = 1'b0;
    end
    chk("fifo_full3", full3, 0);
    chk("fifo_full4", full4, 1);
    chk("fifo_ovf_pulses", ovf_n, 1);
    chk("fifo_count4", fifo_count, 4);
    for (int f = 0; f < 4; f++) begin
      cap(0, 10, v);
      chk($sformatf("fifo_frame%0d", f), v, EXP_F[f]);
      pulse(0);
      chk($sformatf("fifo_gap%0d", f), tx, 1);
    end
    chk("fifo_busy_dn", busy, 0);
    chk("fifo_count0", fifo_count, 0);

    // Config latched at pop
    parity_mode = 2'b10;
    push(0, 8'h3C);
    push(0, 8'hC3);
    cap(0, 4, a);
    parity_mode = 2'b00;
    cap(0, 7, b);
    v = a | (b << 4);
    chk("latch_frame1", v, 16'h678);
    pulse(0);
    chk("latch_gap", tx, 1);
    cap(0, 10, v);
    chk("latch_frame2", v, 16'h386);
    pulse(0);
    chk("latch_busy_dn", busy, 0);

    // 5-bit instance: width and simultaneous push/pop
    push(1, 8'h1F);
    chk("w5_count1", cnt5, 1);
    repeat (15) @(negedge clk);
    enb5 = 1'b1; wr5 = 1'b1; din5 = 5'h0A;
    @(negedge clk);
    enb5 = 1'b0; wr5 = 1'b0;
    chk("w5_pushpop_count", cnt5, 1);
    chk("w5_start", tx5, 0);
    cap(1, 6, v);
    chk("w5_frame1_rest", v, 16'h03F);
    pulse(1);
    chk("w5_gap", tx5, 1);
    cap(1, 7, v);
    chk("w5_frame2", v, 16'h054);
    pulse(1);
    chk("w5_busy_dn", busy5, 0);
    chk("w5_count0", cnt5, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
Parametrised next-generation UART transmitter with configurable frame format and a small input FIFO. Software/host logic pushes bytes with a write strobe. The block serialises them LSB-first as start, data, optional parity and 1 or 2 stop bits, one bit per external baud tick (enb). It sits between the host write path and the UART pad, alongside the existing receiver and baud generator.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9.
FIFO_DEPTH, 4, input FIFO entries; power of two, 2..16.
CNT_W, $clog2(FIFO_DEPTH)+1, occupancy counter width (derived, do not override).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
enb  input  1  baud tick, one-cycle pulse per bit period.
wr_enb  input  1  push data_in into FIFO.
data_in  input  DATA_BITS  byte to send.
parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
two_stop  input  1  1 = two stop bits.
tx  output  1  serial line, idle high.
busy  output  1  frame in progress or FIFO non-empty.
full  output  1  FIFO full.
overflow  output  1  one-cycle pulse: write dropped because FIFO was full.
fifo_count  output  CNT_W  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release by clk): tx=1, busy=0, full=0, overflow=0, fifo_count=0, state IDLE, FIFO pointers 0. Reset mid-frame aborts the frame immediately; tx returns high in the same reset assertion.
- FIFO push: wr_enb with full=0 stores data_in. With full=1, data is dropped, overflow=1 the next cycle, and contents are unchanged. The full value used is the registered value; a same-cycle pop does not make room for that write.
- Pop: happens only in IDLE on an enb cycle with fifo_count>0. It loads the shift register, latches parity_mode and two_stop, and computes parity as the XOR of data (inverted for odd). Config changes mid-frame do not affect the current frame.
- States: IDLE -> START -> DATA -> PARITY -> STOP1 -> STOP2 -> IDLE. Transitions occur only on enb.
  - IDLE: tx=1. On pop: tx<=0, go to START.
  - START: on enb, tx<=bit0, index<=0, go to DATA.
  - DATA: on enb, if index==DATA_BITS-1, go to PARITY (parity enabled, tx<=parity) or STOP1 (tx<=1). Otherwise index++ and tx<=next bit.
  - PARITY: on enb, tx<=1, go to STOP1.
  - STOP1: on enb, go to STOP2 if two_stop latched, else IDLE.
  - STOP2: on enb, go to IDLE.
  - Return to IDLE happens on the tick ending the last stop bit. If the FIFO is non-empty, the next frame does not start on that same tick; it starts on the following enb. One extra idle bit between frames is required.
- Each bit is held from one enb tick to the next, so every bit is exactly one baud period. tx is registered and glitch-free.
- busy = (state!=IDLE) | (fifo_count!=0), registered from next-state values. It rises the cycle after the first accepted write.
- fifo_count increments on push, decrements on pop, and is unchanged on simultaneous push and pop.
- Frame length in bits: 1 + DATA_BITS + (parity?1:0) + (two_stop?2:1).

Decomposition:
- Shared package uart_pkg: state encoding (3-bit enum IDLE..STOP2), parity_mode constants PAR_NONE/PAR_EVEN/PAR_ODD, and parity helper function. The receiver reuses all of these.
- Sub-module uart_sync_fifo (parametrised DATA_W, DEPTH; push/pop/full/empty/count). The transmitter instantiates it. It is reusable on the RX side.

Test Plan:
- Reset mid-frame: push 0xA5, assert rst_n=0 during DATA -> tx=1, busy=0, fifo_count=0 immediately; no further bits after release.
- 8N1: DATA_BITS=8, parity 00, two_stop=0, push 0x53, enb every 16 clk -> tx sequence 0,1,1,0,0,1,0,1,0,1; busy drops after the stop bit.
- Parity: push 0x07 even -> parity bit 1; odd -> parity bit 0. Frame is 11 bits; two_stop=1 gives 12 bits with two high stop bits.
- FIFO full/overflow: FIFO_DEPTH=4, push 5 bytes back-to-back with enb idle -> full=1 after the 4th, overflow pulses once on the 5th, fifo_count=4. The four stored bytes are sent in order, with one idle bit between frames.
- Config latch: start 0x3C with parity odd, switch parity_mode to 00 during DATA -> parity bit still sent (value 1); next frame is sent without parity.
- Width: DATA_BITS=5, push 0x1F (5 bits) -> 0,1,1,1,1,1,1 (7 bits, no parity); simultaneous push and pop leaves fifo_count unchanged.
